// File: rtl/usb_buffer_arbiter.sv
// usb_buffer_arbiter
// Shares the single-port 64-byte buffer SRAM between the host (AHB) side and the
// USB RX/TX engines. Each side has a one-deep pending slot. A round-robin pick
// settles contention, and one memory operation is issued per cycle. The block
// owns the read/write pointers, the committed occupancy count and the clear sequence.
module usb_buffer_arbiter #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              Clear,
  input  logic              Get_RX_Data,
  input  logic              Store_TX_Data,
  input  logic [DATA_W-1:0] TX_Data,
  output logic [DATA_W-1:0] RX_Data,
  output logic              host_rd_valid,
  input  logic              usb_store,
  input  logic [DATA_W-1:0] usb_wdata,
  input  logic              usb_get,
  output logic [DATA_W-1:0] usb_rdata,
  output logic              usb_rd_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   Buffer_Occupancy,
  output logic              overflow,
  output logic              underflow,
  output logic              req_drop
);

  typedef enum logic {ST_READY, ST_CLEARING} state_t;
  typedef enum logic {SIDE_HOST, SIDE_USB} side_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  side_t             rr_pri, rr_pri_nxt;
  req_t              host_pend, usb_pend, host_pend_nxt, usb_pend_nxt;
  req_t              host_new, usb_new, host_req, usb_req, grant_req;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   occ;
  logic              active, flush;
  logic              grant_host, grant_usb, grant_any;
  logic              do_write, do_read, ovf, udf;
  logic              host_busy_drop, usb_busy_drop;
  logic              host_uf_now, usb_uf_now;
  logic              rd_inflight;
  side_t             rd_side;
  logic              host_uf_pend, usb_uf_pend;

  assign Buffer_Occupancy = occ;

  // Present each side's request: the held slot if there is one, otherwise this cycle's pulse.
  always_comb begin
    host_new       = '{valid: Store_TX_Data | Get_RX_Data, is_write: Store_TX_Data, data: TX_Data};
    usb_new        = '{valid: usb_store | usb_get, is_write: usb_store, data: usb_wdata};
    host_req       = host_pend.valid ? host_pend : host_new;
    usb_req        = usb_pend.valid ? usb_pend : usb_new;
    host_busy_drop = host_pend.valid & (Store_TX_Data | Get_RX_Data);
    usb_busy_drop  = usb_pend.valid & (usb_store | usb_get);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (!n_rst) state <= ST_READY;
    else        state <= state_nxt;
  end

  // FSM next state: a Clear pulse costs exactly one CLEARING cycle.
  always_comb begin
    // NOTE: defaulting every comb output first keeps each path fully assigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      ST_READY:    if (Clear) state_nxt = ST_CLEARING;
      ST_CLEARING: state_nxt = ST_READY;
      default:     state_nxt = ST_READY;
    endcase
  end

  // FSM outputs: arbitration, full/empty checks against the committed count, and the SRAM port.
  always_comb begin
    flush       = (state == ST_CLEARING) || Clear;
    active      = n_rst && (state == ST_READY) && !Clear;
    grant_host  = active && host_req.valid && (!usb_req.valid || rr_pri == SIDE_HOST);
    grant_usb   = active && usb_req.valid && (!host_req.valid || rr_pri == SIDE_USB);
    grant_any   = grant_host || grant_usb;
    grant_req   = grant_host ? host_req : usb_req;
    do_write    = grant_any && grant_req.is_write && (occ != FULL);
    ovf         = grant_any && grant_req.is_write && (occ == FULL);
    do_read     = grant_any && !grant_req.is_write && (occ != '0);
    udf         = grant_any && !grant_req.is_write && (occ == '0);
    host_uf_now = udf && grant_host;
    usb_uf_now  = udf && grant_usb;
    mem_en      = do_write || do_read;
    mem_we      = do_write;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (do_write) begin
      mem_addr  = wr_ptr;
      mem_wdata = grant_req.data;
    end else if (do_read) begin
      mem_addr  = rd_ptr;
    end
    overflow    = ovf;
    underflow   = udf;
    req_drop    = active && ((Store_TX_Data && Get_RX_Data) || (usb_store && usb_get) ||
                             host_busy_drop || usb_busy_drop);
  end

  // Slot and priority update: a loser is held for next cycle, and rr_pri moves only on contention.
  always_comb begin
    host_pend_nxt = '0;
    usb_pend_nxt  = '0;
    rr_pri_nxt    = rr_pri;
    if (active) begin
      if (host_req.valid && !grant_host) host_pend_nxt = host_req;
      if (usb_req.valid && !grant_usb)   usb_pend_nxt  = usb_req;
      if (host_req.valid && usb_req.valid) rr_pri_nxt = grant_host ? SIDE_USB : SIDE_HOST;
    end
  end

  // Pointer, occupancy and slot registers; the Clear cycle and the CLEARING cycle both zero them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      host_pend <= '0;
      usb_pend  <= '0;
      rr_pri    <= SIDE_HOST;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      host_pend <= host_pend_nxt;
      usb_pend  <= usb_pend_nxt;
      rr_pri    <= rr_pri_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
        occ    <= occ + 1'b1;
      end else if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
        occ    <= occ - 1'b1;
      end
    end
  end

  // Return path: a real read returns SRAM data two cycles after its grant, and an underflow
  // returns zero one cycle after. If both land on the same cycle, the zero waits one more.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_inflight   <= 1'b0;
      rd_side       <= SIDE_HOST;
      RX_Data       <= '0;
      host_rd_valid <= 1'b0;
      usb_rdata     <= '0;
      usb_rd_valid  <= 1'b0;
      host_uf_pend  <= 1'b0;
      usb_uf_pend   <= 1'b0;
    end else begin
      rd_inflight   <= do_read;
      rd_side       <= grant_host ? SIDE_HOST : SIDE_USB;
      host_rd_valid <= 1'b0;
      usb_rd_valid  <= 1'b0;

      if (rd_inflight && rd_side == SIDE_HOST) begin
        RX_Data       <= mem_rdata;
        host_rd_valid <= 1'b1;
        host_uf_pend  <= host_uf_pend || host_uf_now;
      end else if (host_uf_pend || host_uf_now) begin
        RX_Data       <= '0;
        host_rd_valid <= 1'b1;
        host_uf_pend  <= host_uf_pend && host_uf_now;
      end

      if (rd_inflight && rd_side == SIDE_USB) begin
        usb_rdata    <= mem_rdata;
        usb_rd_valid <= 1'b1;
        usb_uf_pend  <= usb_uf_pend || usb_uf_now;
      end else if (usb_uf_pend || usb_uf_now) begin
        usb_rdata    <= '0;
        usb_rd_valid <= 1'b1;
        usb_uf_pend  <= usb_uf_pend && usb_uf_now;
      end
    end
  end

endmodule
